// File: rtl/chip8_regfile_xfer_if.sv
// Command bus (CPU -> sequencer) and memory beat bus (sequencer -> memory) for chip8_regfile_xfer.
// The master drives commands and memory responses; the slave is the register-file sequencer.
interface chip8_regfile_xfer_if #(
   parameter int RW = 4,
   parameter int DW = 8,
   parameter int AW = 12
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [RW-1:0] cmd_last;
   logic [AW-1:0] cmd_addr;
   logic          busy;
   logic          done;
   logic          err;
   logic          mem_req;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output cmd_valid, cmd_op, cmd_last, cmd_addr, mem_rdata, mem_ack,
      input  cmd_ready, busy, done, err, mem_req, mem_wr, mem_addr, mem_wdata
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_last, cmd_addr, mem_rdata, mem_ack,
      output cmd_ready, busy, done, err, mem_req, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/chip8_regfile_xfer.sv
// V-register file with block-transfer sequencer to memory / RPL store; CHIP8_XFER_INC_I_EN adds i_next/i_update.
// Reads combinational; a transfer of last+1 entries completes with done last+2 cycles after acceptance, memory beats stall on mem_ack.
module chip8_regfile_xfer #(
   parameter int NREG      = 16,
   parameter int DW        = 8,
   parameter int AW        = 12,
   parameter int RPL_DEPTH = 8,
   localparam int RW       = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          res_n,
   input  logic [RW-1:0] x,
   input  logic [RW-1:0] y,
   output logic [DW-1:0] vx,
   output logic [DW-1:0] vy,
   input  logic          wx,
   input  logic [DW-1:0] nx,
   input  logic          wf,
   input  logic [DW-1:0] nf,
   chip8_regfile_xfer_if.slave bus
`ifdef CHIP8_XFER_INC_I_EN
   ,
   output logic [AW-1:0] i_next,
   output logic          i_update
`endif
);

   localparam int PW = (RPL_DEPTH > 1) ? $clog2(RPL_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_RPL, S_DONE} state_t;

   state_t        state;
   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] rpl  [RPL_DEPTH];
   logic          load_q;
   logic [RW-1:0] last_q;
   logic [RW-1:0] idx_q;
   logic [AW-1:0] addr_q;
   logic [RW-1:0] idx_inc;
   logic [PW-1:0] ridx;
   logic          rpl_bad;

   assign idx_inc = idx_q + RW'(1);
   assign ridx    = idx_q[PW-1:0];
   assign rpl_bad = (int'(bus.cmd_last) >= RPL_DEPTH);
   assign vx      = regs[x];
   assign vy      = regs[y];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state  <= S_IDLE;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         for (int i = 0; i < RPL_DEPTH; i++) rpl[i] <= '0;
         load_q <= 1'b0;
         last_q <= '0;
         idx_q  <= '0;
         addr_q <= '0;
         bus.cmd_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
`ifdef CHIP8_XFER_INC_I_EN
         i_next   <= '0;
         i_update <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
`ifdef CHIP8_XFER_INC_I_EN
         i_update <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // Flag write is last so it wins when both target register NREG-1.
               if (wx) regs[x] <= nx;
               if (wf) regs[NREG-1] <= nf;
               if (bus.cmd_valid) begin
                  if (bus.cmd_op[1] && rpl_bad) begin
                     bus.err <= 1'b1;
                  end else begin
                     load_q        <= bus.cmd_op[0];
                     last_q        <= bus.cmd_last;
                     addr_q        <= bus.cmd_addr;
                     idx_q         <= '0;
                     bus.busy      <= 1'b1;
                     bus.cmd_ready <= 1'b0;
                     if (bus.cmd_op[1]) begin
                        state <= S_RPL;
                     end else begin
                        state         <= S_MEM;
                        bus.mem_req   <= 1'b1;
                        bus.mem_wr    <= ~bus.cmd_op[0];
                        bus.mem_addr  <= bus.cmd_addr;
                        bus.mem_wdata <= regs[0];
                     end
                  end
               end
            end

            S_MEM: begin
               if (bus.mem_ack) begin
                  if (load_q) regs[idx_q] <= bus.mem_rdata;
                  if (idx_q == last_q) begin
                     state       <= S_DONE;
                     bus.mem_req <= 1'b0;
                     bus.mem_wr  <= 1'b0;
                     bus.done    <= 1'b1;
`ifdef CHIP8_XFER_INC_I_EN
                     i_update <= 1'b1;
                     i_next   <= addr_q + AW'(last_q) + AW'(1);
`endif
                  end else begin
                     // Next beat is presented immediately so zero-wait memory runs one beat per cycle.
                     idx_q         <= idx_inc;
                     bus.mem_addr  <= addr_q + AW'(idx_inc);
                     bus.mem_wdata <= regs[idx_inc];
                  end
               end
            end

            S_RPL: begin
               if (load_q) regs[idx_q] <= rpl[ridx];
               else        rpl[ridx]   <= regs[idx_q];
               if (idx_q == last_q) begin
                  state    <= S_DONE;
                  bus.done <= 1'b1;
               end else begin
                  idx_q <= idx_inc;
               end
            end

            default: begin
               state         <= S_IDLE;
               bus.busy      <= 1'b0;
               bus.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_regfile_xfer.sv
// Randomised scoreboard bench for chip8_regfile_xfer: expected beats and completions are queued at issue time
// from an array-level reference model, and a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_chip8_regfile_xfer;
   localparam int NREG = 16, RW = 4, DW = 8, AW = 12, RPL_DEPTH = 8;
   localparam int MSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          res_n = 1'b0;
   logic [RW-1:0] x = '0, y = '0;
   logic [DW-1:0] vx, vy;
   logic          wx = 1'b0, wf = 1'b0;
   logic [DW-1:0] nx = '0, nf = '0;
`ifdef CHIP8_XFER_INC_I_EN
   logic [AW-1:0] i_next;
   logic          i_update;
`endif

   chip8_regfile_xfer_if #(.RW(RW), .DW(DW), .AW(AW)) bus ();

   chip8_regfile_xfer #(.NREG(NREG), .DW(DW), .AW(AW), .RPL_DEPTH(RPL_DEPTH)) dut (
      .clk   (clk),
      .res_n (res_n),
      .x     (x),
      .y     (y),
      .vx    (vx),
      .vy    (vy),
      .wx    (wx),
      .nx    (nx),
      .wf    (wf),
      .nf    (nf),
      .bus   (bus)
`ifdef CHIP8_XFER_INC_I_EN
      , .i_next(i_next), .i_update(i_update)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
   typedef struct { logic is_err; int lat; logic iupd; logic [AW-1:0] inext; } evt_t;

   beat_t beat_q[$];
   evt_t  evt_q[$];
   int checks = 0, failures = 0, cyc = 0, accept_cyc = 0;
   logic [DW-1:0] ref_regs [NREG];
   logic [DW-1:0] ref_rpl  [RPL_DEPTH];
   logic [DW-1:0] ref_mem  [MSZ];
   logic [DW-1:0] dev_mem  [MSZ];
   bit ack_tied = 1'b1;
   int min_delay = 0, max_delay = 0, cur_delay = 0, wait_cnt = 0;
   bit prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic          prev_wr;
   logic [DW-1:0] prev_wd;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Memory device, ack generator and scoreboard monitor.
   always @(negedge clk) begin
      beat_t b;
      evt_t  e;
      if (!res_n) begin
         bus.mem_ack = ack_tied;
         prev_stall  = 1'b0;
         wait_cnt    = 0;
      end else begin
         if (prev_stall && bus.mem_req) begin
            chk("stall_addr", bus.mem_addr, prev_addr);
            chk("stall_wr", bus.mem_wr, prev_wr);
            chk("stall_wdata", bus.mem_wdata, prev_wd);
         end
         if (ack_tied) bus.mem_ack = 1'b1;
         else if (!bus.mem_req) begin bus.mem_ack = 1'b0; wait_cnt = 0; end
         else if (wait_cnt >= cur_delay) begin
            bus.mem_ack = 1'b1;
            wait_cnt    = 0;
            cur_delay   = $urandom_range(max_delay, min_delay);
         end else begin
            bus.mem_ack = 1'b0;
            wait_cnt++;
         end
         bus.mem_rdata = dev_mem[bus.mem_addr];
         if (bus.mem_req && bus.mem_ack) begin
            if (beat_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat actual=addr 0x%0h required=no beat", bus.mem_addr);
            end else begin
               b = beat_q.pop_front();
               chk("beat_wr", bus.mem_wr, b.wr);
               chk("beat_addr", bus.mem_addr, b.addr);
               if (b.wr) chk("beat_wdata", bus.mem_wdata, b.data);
            end
            if (bus.mem_wr) dev_mem[bus.mem_addr] = bus.mem_wdata;
         end
         prev_stall = bus.mem_req && !bus.mem_ack;
         prev_addr  = bus.mem_addr;
         prev_wr    = bus.mem_wr;
         prev_wd    = bus.mem_wdata;
         if (bus.done || bus.err) begin
            if (evt_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_completion actual=done %0b err %0b required=none", bus.done, bus.err);
            end else begin
               e = evt_q.pop_front();
               chk("evt_err", bus.err, e.is_err);
               chk("evt_done", bus.done, !e.is_err);
               if (e.lat > 0) chk("evt_latency", cyc - accept_cyc + 1, e.lat);
               if (!e.is_err) chk("beats_left", beat_q.size(), 0);
`ifdef CHIP8_XFER_INC_I_EN
               chk("i_update", i_update, e.iupd);
               if (e.iupd) chk("i_next", i_next, e.inext);
`endif
            end
         end
      end
   end

   task automatic wr_reg(input int i, input logic [DW-1:0] d);
      @(posedge clk); #1;
      x = RW'(i); nx = d; wx = 1'b1;
      @(posedge clk); #1;
      wx = 1'b0;
      ref_regs[i] = d;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREG; i++) begin
         x = RW'(i); y = RW'(NREG - 1 - i);
         #1;
         chk({tag, "_vx"}, vx, ref_regs[i]);
         chk({tag, "_vy"}, vy, ref_regs[NREG-1-i]);
      end
   endtask

   task automatic issue(input logic [1:0] op, input int last, input logic [AW-1:0] addr);
      evt_t  e;
      beat_t b;
      int    a;
      if (op[1] && last >= RPL_DEPTH) begin
         e.is_err = 1'b1; e.lat = 1; e.iupd = 1'b0; e.inext = '0;
      end else begin
         for (int i = 0; i <= last; i++) begin
            a = (int'(addr) + i) % MSZ;
            case (op)
               2'd0: begin
                  b.wr = 1'b1; b.addr = AW'(a); b.data = ref_regs[i];
                  beat_q.push_back(b);
                  ref_mem[a] = ref_regs[i];
               end
               2'd1: begin
                  b.wr = 1'b0; b.addr = AW'(a); b.data = '0;
                  beat_q.push_back(b);
                  ref_regs[i] = ref_mem[a];
               end
               2'd2: ref_rpl[i] = ref_regs[i];
               default: ref_regs[i] = ref_rpl[i];
            endcase
         end
         e.is_err = 1'b0;
         e.lat    = (ack_tied || op[1]) ? last + 2 : 0;
         e.iupd   = !op[1];
         e.inext  = AW'((int'(addr) + last + 1) % MSZ);
      end
      evt_q.push_back(e);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_last = RW'(last); bus.cmd_addr = addr;
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      @(posedge clk); #1;
      accept_cyc = cyc;
      bus.cmd_valid = 1'b0;
      chk("busy_after_accept", bus.busy, !e.is_err);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (evt_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
      if (evt_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL timeout actual=%0d pending required=0", evt_q.size());
         evt_q.delete(); beat_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_last = '0; bus.cmd_addr = '0;
      for (int i = 0; i < MSZ; i++) begin v = DW'($urandom); ref_mem[i] = v; dev_mem[i] = v; end
      for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
      for (int i = 0; i < RPL_DEPTH; i++) ref_rpl[i] = '0;

      repeat (3) @(posedge clk); #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      @(negedge clk); res_n = 1'b1;
      check_regs("rst");

      wr_reg(3, 8'h5A);
      x = 3; #1;
      chk("wx_vx", vx, 8'h5A);
      @(posedge clk); #3;
      res_n = 1'b0; #1;
      chk("async_rst_vx", vx, 0);
      ref_regs[3] = '0;
      #1 res_n = 1'b1;

      for (int n = 0; n < NREG; n++) wr_reg(n, DW'(8'h10 + n));
      ack_tied = 1'b1;
      issue(2'd0, 15, 12'hFF8);
      wait_done(200);
      check_regs("store");

      ref_mem[12'h300] = 8'hAA; dev_mem[12'h300] = 8'hAA;
      ref_mem[12'h301] = 8'hBB; dev_mem[12'h301] = 8'hBB;
      ref_mem[12'h302] = 8'hCC; dev_mem[12'h302] = 8'hCC;
      ack_tied = 1'b0; min_delay = 3; max_delay = 3; cur_delay = 3;
      issue(2'd1, 2, 12'h300);
      wait_done(200);
      check_regs("load");

      ack_tied = 1'b1;
      for (int i = 0; i < NREG; i++) wr_reg(i, DW'($urandom));
      issue(2'd2, 7, '0);
      wait_done(200);
      for (int i = 0; i < 8; i++) wr_reg(i, DW'($urandom));
      issue(2'd3, 7, '0);
      wait_done(200);
      check_regs("rpl");
      issue(2'd2, 8, '0);
      wait_done(50);
      for (int i = 0; i < 8; i++) wr_reg(i, DW'($urandom));
      issue(2'd3, 7, '0);
      wait_done(200);
      check_regs("rpl_after_err");

      @(posedge clk); #1;
      x = 4'd15; nx = 8'h01; wx = 1'b1; nf = 8'h00; wf = 1'b1;
      @(posedge clk); #1;
      wx = 1'b0; wf = 1'b0;
      ref_regs[15] = 8'h00;
      x = 4'd15; #1;
      chk("wf_wins", vx, 0);

      ack_tied = 1'b0; min_delay = 2; max_delay = 2; cur_delay = 2;
      issue(2'd0, 3, 12'h100);
      @(posedge clk); #1;
      x = 4'd5; nx = ~ref_regs[5]; wx = 1'b1; nf = ~ref_regs[15]; wf = 1'b1;
      @(posedge clk); #1;
      wx = 1'b0; wf = 1'b0;
      wait_done(200);
      check_regs("busy_wr");

      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(1, 0) == 1) wr_reg($urandom_range(NREG - 1, 0), DW'($urandom));
         ack_tied = ($urandom_range(1, 0) == 1);
         min_delay = 0; max_delay = 3; cur_delay = $urandom_range(3, 0);
         issue(2'($urandom_range(3, 0)), $urandom_range(NREG - 1, 0), AW'($urandom));
         wait_done(300);
         check_regs("rand");
      end

      ack_tied = 1'b1;
      issue(2'd0, 15, 12'h800);
      @(posedge clk); @(posedge clk); #1;
      chk("third_beat_req", bus.mem_req, 1);
      chk("third_beat_addr", bus.mem_addr, 12'h802);
      res_n = 1'b0; #1;
      chk("abort_mem_req", bus.mem_req, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_cmd_ready", bus.cmd_ready, 1);
      beat_q.delete(); evt_q.delete();
      for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
      for (int i = 0; i < RPL_DEPTH; i++) ref_rpl[i] = '0;
      @(negedge clk); res_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("after_abort_busy", bus.busy, 0);
      chk("after_abort_mem_req", bus.mem_req, 0);
      check_regs("after_abort");
      wr_reg(0, 8'h77);
      issue(2'd3, 0, '0);
      wait_done(50);
      check_regs("rpl_reset");

`ifdef CHIP8_XFER_INC_I_EN
      issue(2'd1, 4, 12'h200);
      wait_done(100);
      check_regs("inc_i");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/chip8_regfile_xfer.md
Name: chip8_regfile_xfer

Overview:
- Parametrised successor to the CPU's V-register file.
- Provides 2 combinational read ports, a direct write port and a flag write port.
- Adds an autonomous block-transfer sequencer that moves registers V0..Vlast to or from memory (Fx55/Fx65) or the RPL flag store (Fx75/Fx85).
- The CPU issues one command and waits for done, replacing the per-instruction transfer states in the CPU FSM.

Parameters:
NREG, 16, number of V registers (power of 2, >=2); RW = log2(NREG)
DW, 8, register data width
AW, 12, memory address width
RPL_DEPTH, 8, RPL store entries (<= NREG)

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
x  in  RW  read port X index
y  in  RW  read port Y index
vx  out  DW  register[x], combinational
vy  out  DW  register[y], combinational
wx  in  1  write enable, register[x] <= nx
nx  in  DW  write data for X
wf  in  1  write enable, register[NREG-1] <= nf
nf  in  DW  flag write data
cmd_valid  in  1  transfer command request
cmd_ready  out  1  high in IDLE only
cmd_op  in  2  00 store-to-mem, 01 load-from-mem, 10 save-to-RPL, 11 restore-from-RPL
cmd_last  in  RW  index of last register transferred (inclusive)
cmd_addr  in  AW  memory start address (I)
busy  out  1  sequencer not IDLE
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse on rejected command
mem_req  out  1  memory beat request
mem_wr  out  1  1 = write beat
mem_addr  out  AW  beat address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid in the mem_ack cycle
mem_ack  in  1  beat accepted/completed this cycle

Behaviour:
- Reset (async, res_n=0): all registers and RPL entries = 0; state IDLE; mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, cmd_ready=1.
- Reset asserted mid-transfer aborts immediately; no further beats are issued.
- Command acceptance: cmd_valid && cmd_ready on a rising edge latches op, last, addr, and sets index=0.
  - RPL op with cmd_last >= RPL_DEPTH: rejected; err pulses the next cycle; state stays IDLE; no register changes.
- States:
  - IDLE: waits for a command. Next state MEM (op 00/01) or RPL (op 10/11).
  - MEM: mem_req=1, mem_addr=addr+index (mod 2^AW, wraps), mem_wr=(op==00), mem_wdata=register[index].
    - On mem_ack: op 01 writes register[index] <= mem_rdata.
    - If index==last, go to DONE; else index++ and stay in MEM with mem_req still high, so back-to-back beats run at 1 beat/cycle.
    - Without mem_ack, address, write flag and data hold stable.
  - RPL: one entry per cycle. Op 10: rpl[index] <= register[index]. Op 11: register[index] <= rpl[index]. Index==last goes to DONE.
  - DONE: done=1 for one cycle, mem_req=0; then IDLE. cmd_ready rises in IDLE, so there is a 1-cycle minimum gap between commands.
- Latency, zero-wait memory (ack tied high): last+1 beat cycles + 1 DONE cycle after acceptance. Example: last=15 gives done 17 cycles after acceptance.
- Write priority:
  - wx and wf targeting the same register in the same cycle: wf wins.
  - wx/wf while busy: ignored.
  - A sequencer write and a port write never coincide.
- vx/vy reflect the current contents, including mid-transfer updates.
- Widths: all arithmetic is unsigned modulo its width; index counts 0..last (never wraps because last <= NREG-1).

Optional Feature:
CHIP8_XFER_INC_I_EN
- Defined: adds outputs i_next (AW) and i_update (1). i_update pulses together with done for op 00/01 only, with i_next = cmd_addr+cmd_last+1 mod 2^AW (original COSMAC semantics, I incremented).
- Not defined: both ports are absent; I is never modified by this block.

Test Plan:
- Reset then wx with x=3, nx=0x5A; read x=3 -> vx=0x5A. Assert res_n=0 -> vx=0 asynchronously, before the next edge.
- Load V0..V15 with 0x10+n; op 00, last=15, addr=0xFF8, ack tied 1 -> 16 write beats at 0xFF8..0xFFF then 0x000..0x007 (wrap), data 0x10..0x1F; done 17 cycles after acceptance.
- Op 01, last=2, addr=0x300, ack delayed 3 cycles per beat, memory 0xAA/0xBB/0xCC -> V0..V2=AA/BB/CC, V3 unchanged; mem_addr stable during stalls.
- Op 10 last=7, overwrite regs, then op 11 last=7 -> V0..V7 restored, V8..V15 unchanged. Op 10 last=8 -> err pulse, no state change.
- Same cycle wx (x=15, nx=0x01) and wf (nf=0x00) -> VF=0x00. wx during busy -> ignored.
- Res_n low on the third beat of a store -> mem_req=0 immediately; after release busy=0 and all regs 0. With CHIP8_XFER_INC_I_EN: op 01, addr=0x200, last=4 -> i_next=0x205 with done.
